// File: rtl/bdi_line_fetcher.sv
// bdi_line_fetcher: assembles a BDI line-pair (mode, base, payload beats) from a word stream; BDI_FETCH_ERR_EN enables fetch_err
module bdi_line_fetcher #(
  parameter int WORD_WIDTH = 32,
  parameter logic [3:0] RPV4_CODE = 4'b0000,
  parameter logic [3:0] RPV8_CODE = 4'b0001,
  parameter logic [3:0] B8D1_CODE = 4'b0010,
  parameter logic [3:0] B8D2_CODE = 4'b0011,
  parameter logic [3:0] B8D4_CODE = 4'b0100,
  parameter logic [3:0] B4D1_CODE = 4'b0101,
  parameter logic [3:0] B4D2_CODE = 4'b0110,
  parameter logic [3:0] B2D1_CODE = 4'b0111,
  parameter logic [3:0] NO_COMPR_CODE = 4'b1111
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*WORD_WIDTH-1:0] compressed_cachelines,
  output logic [7:0]              compressed_mode,
  output logic [31:0]             base_one_hot,
  output logic                    fetch_err
);
  typedef enum logic [1:0] {HDR_MODE, HDR_BASE, PAYLOAD, OUT} state_t;
  state_t state;
  logic [2:0] cnt, last, last_n;
  logic [3:0] ls, ms;
  logic [6:0] t, q;
  logic full;
  function automatic logic [6:0] size_of(input logic [3:0] c);
    return c == RPV4_CODE ? 7'd4 : c == RPV8_CODE ? 7'd8 :
           (c == B8D1_CODE || c == B4D1_CODE) ? 7'd12 : c == B8D2_CODE ? 7'd16 :
           c == B2D1_CODE ? 7'd18 : c == B4D2_CODE ? 7'd20 : c == B8D4_CODE ? 7'd24 : 7'd32;
  endfunction
  function automatic logic known(input logic [3:0] c);
    return c == NO_COMPR_CODE || size_of(c) != 7'd32;
  endfunction
  always_comb begin
    ls = in_data[3:0];
    ms = in_data[7:4];
    t = size_of(ls) + size_of(ms);
    q = (t + 7'd3) >> 2;
    full = ls == NO_COMPR_CODE || ms == NO_COMPR_CODE || !known(ls) || !known(ms);
    last_n = (full || q >= 7'd8) ? 3'd7 : q[2:0] - 3'd1;
  end
  assign in_ready = !rst && state != OUT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR_MODE;
      out_valid <= 1'b0;
      compressed_cachelines <= '0;
      compressed_mode <= '0;
      base_one_hot <= '0;
      cnt <= '0;
      last <= '0;
    end else begin
      case (state)
        HDR_MODE: if (in_valid) begin
          compressed_mode <= in_data[7:0];
          compressed_cachelines <= '0;
          last <= last_n;
          state <= HDR_BASE;
        end
        HDR_BASE: if (in_valid) begin
          base_one_hot <= in_data[31:0];
          cnt <= '0;
          state <= PAYLOAD;
        end
        PAYLOAD: if (in_valid) begin
          compressed_cachelines[cnt*WORD_WIDTH +: WORD_WIDTH] <= in_data;
          cnt <= cnt == last ? 3'd0 : cnt + 3'd1;
          if (cnt == last) begin
            state <= OUT;
            out_valid <= 1'b1;
          end
        end
        default: if (out_ready) begin
          out_valid <= 1'b0;
          state <= HDR_MODE;
        end
      endcase
    end
  end
`ifdef BDI_FETCH_ERR_EN
  logic hdr_err;
  assign hdr_err = !known(ls) || !known(ms) || (t > 7'd32 && ls != NO_COMPR_CODE && ms != NO_COMPR_CODE);
  always_ff @(posedge clk) begin
    if (rst) fetch_err <= 1'b0;
    else if (state == HDR_MODE && in_valid && hdr_err) fetch_err <= 1'b1;
  end
`else
  assign fetch_err = 1'b0;
`endif
endmodule

// File: doc/bdi_line_fetcher.md
Name: bdi_line_fetcher

Overview:
- Sequential front-end for the BDI pair decompressor.
- Receives a compressed line-pair from memory as a stream of WORD_WIDTH beats: a mode header, a base one-hot header, then only the payload words the two modes actually need.
- Assembles the 256-bit compressed block, mode byte and base one-hot, and holds them behind a valid/ready handshake.
- Its outputs drive the decompressor's compressed_cachelines, compressed_mode and base_one_hot inputs directly.

Parameters:
- WORD_WIDTH, 32: beat width; block supports 32 only; payload buffer is 8*WORD_WIDTH.
- RPV4_CODE, 4'b0000: 4-byte line encoding.
- RPV8_CODE, 4'b0001: 8-byte line encoding.
- B8D1_CODE / B8D2_CODE / B8D4_CODE, 4'b0010 / 4'b0011 / 4'b0100: 12 / 16 / 24 bytes.
- B4D1_CODE / B4D2_CODE / B2D1_CODE, 4'b0101 / 4'b0110 / 4'b0111: 12 / 20 / 18 bytes.
- NO_COMPR_CODE, 4'b1111: 32 bytes.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  WORD_WIDTH  header or payload beat.
- out_valid  out  1  assembled block available.
- out_ready  in  1  consumer (decompressor stage) takes block.
- compressed_cachelines  out  8*WORD_WIDTH  assembled payload; beat k at [32k+31:32k].
- compressed_mode  out  8  [3:0] LS line mode, [7:4] MS line mode.
- base_one_hot  out  32  base one-hot from header beat 1.
- fetch_err  out  1  sticky illegal-mode / overflow flag (optional feature).

Behaviour:
- Reset values: out_valid=0, in_ready=0 during the rst cycle, compressed_cachelines=0, compressed_mode=0, base_one_hot=0, fetch_err=0. State goes to HDR_MODE.
- Reset mid-operation discards the partial block and any pending output. Next accepted beat is treated as a mode header.
- State HDR_MODE: in_ready=1. On accept, latch in_data[7:0] into compressed_mode, clear the payload buffer to 0, compute beat count N, go to HDR_BASE. Bits [31:8] ignored.
- State HDR_BASE: in_ready=1. On accept, latch in_data into base_one_hot, clear beat counter, go to PAYLOAD.
- Size per mode (bytes): RPV4 4, RPV8 8, B8D1 12, B4D1 12, B8D2 16, B2D1 18, B4D2 20, B8D4 24, NO_COMPR 32.
- Any undefined code is sized 32.
- T = size(LS) + size(MS), computed in 7 bits.
- If either mode is NO_COMPR or undefined, N=8; otherwise N = min(8, (T+3)>>2).
- State PAYLOAD: in_ready=1. Each accept writes in_data into word slot = counter and increments the counter. On the accept with counter==N-1, go to OUT. Unwritten words stay 0.
- State OUT: in_ready=0; out_valid=1 from the cycle after the last payload accept. Outputs stay stable while out_valid && !out_ready.
- On out_ready, go to HDR_MODE. out_valid drops the next cycle, and in_ready rises that same next cycle. There is no accept/emit overlap.
- Minimum block latency: last payload accept to out_valid = 1 cycle. Throughput: N+3 cycles per block with ready always high.
- in_valid low in any input state: hold state and counter (bubbles allowed anywhere).
- Counter is 3 bits and never wraps past N-1.

Optional Feature:
- Macro: BDI_FETCH_ERR_EN.
- When defined: fetch_err is set to 1 on a mode-header accept that has either nibble undefined (not one of the nine codes) or T>32 with neither nibble NO_COMPR. Examples of T>32: B2D1+B2D1=36, B8D4+B8D1=36.
- fetch_err stays set until rst. The block is still fetched with N=8 and delivered normally.
- When undefined: fetch_err is tied to 0, with no checking logic. Sizing, N, and block delivery are identical to the defined case.

Test Plan:
- Mode 8'h00 (RPV4/RPV4), base 32'h0000_0003, payload 32'hAAAA_AAAA, 32'hBBBB_BBBB -> exactly 2 payload beats accepted; out_valid 1 cycle after 2nd; compressed_cachelines[63:0]=64'hBBBBBBBB_AAAAAAAA, upper bits 0, base_one_hot=3.
- Mode 8'h57 (LS B2D1 18B, MS B4D1 12B, T=30) -> N=8 beats; all 8 words placed in order; in_ready low in OUT.
- Mode 8'hF0 -> N=8, fetch_err stays 0. Mode 8'h77 -> N=8; fetch_err=1 only with BDI_FETCH_ERR_EN, else 0.
- Back-pressure: out_ready low 5 cycles -> outputs stable, in_ready=0; out_ready high -> next cycle out_valid=0, in_ready=1, next header accepted.
- in_valid toggling every other cycle with mode 8'h11 (RPV8/RPV8, N=4) -> 4 payload words land in slots 0..3 with no skips.
- rst asserted after 3 of 8 payload beats -> next cycle out_valid=0, state HDR_MODE; a fresh 8'h00 block completes correctly with no stale words.
